// File: rtl/t05_pkg.sv
// Shared definitions for the team_05 translation encoder/decoder pair.
// Holds the FSM state type and the default path/character widths.
package t05_pkg;

  localparam int PATH_W_DEFAULT = 128;
  localparam int CHAR_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    INIT         = 3'd0,
    CAPTURE_CHAR = 3'd1,
    REQ_PATH     = 3'd2,
    LOAD_PATH    = 3'd3,
    WRITE_PATH   = 3'd4,
    FINISH       = 3'd5
  } state_te;

  // bit_count is at least 8 bits wide; it only grows for paths longer than 256 bits
  function automatic int bit_count_w(input int path_w);
    return ($clog2(path_w) > 8) ? $clog2(path_w) : 8;
  endfunction

endpackage

// File: rtl/t05_path_shifter.sv
// PATH_W-bit codebook path register: parallel load, MSB-first shift-out,
// with a beat counter that flags the final bit of the path.
module t05_path_shifter
  import t05_pkg::*;
#(
  parameter int PATH_W = PATH_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [PATH_W-1:0] data,
  output logic              msb,
  output logic              last
);

  localparam int CNT_W = bit_count_w(PATH_W);

  logic [PATH_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

  always_comb begin
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    if (load) begin
      shift_d     = data;
      bit_count_d = '0;
    end else if (shift) begin
      shift_d     = {shift_q[PATH_W-2:0], 1'b0};
      bit_count_d = bit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_count_q <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign msb  = shift_q[PATH_W-1];
  assign last = (bit_count_q == CNT_W'(PATH_W - 1));

endmodule

// File: rtl/t05_translation_encode.sv
// Huffman translation encoder: reads raw bytes, fetches each byte's codebook
// path and streams it MSB-first. Optional bits_written counter: T05_ENCODE_BITCOUNT_EN.
module t05_translation_encode
  import t05_pkg::*;
#(
  parameter int PATH_W = PATH_W_DEFAULT,
  parameter int CHAR_W = CHAR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              translation_enable,
  input  logic [31:0]       tot_chars,
  input  logic [CHAR_W-1:0] SPI_data_in,
  input  logic [PATH_W-1:0] SRAM_data_in,
  input  logic              SPI_write_ready,
  output logic              SPI_read_en,
  output logic              SRAM_read_en,
  output logic [CHAR_W-1:0] char_index,
  output logic              SPI_data_out,
  output logic              SPI_write_en,
  output logic              finished
`ifdef T05_ENCODE_BITCOUNT_EN
  ,
  output logic [39:0]       bits_written
`endif
);

  state_te           state_q, state_d;
  logic [CHAR_W-1:0] char_index_q, char_index_d;
  logic [31:0]       tot_chars_q, tot_chars_d;
  logic [31:0]       chars_done_q, chars_done_d;
  logic [31:0]       chars_done_inc;

  logic load;
  logic shift;
  logic path_msb;
  logic path_last;

  t05_path_shifter #(
    .PATH_W(PATH_W)
  ) u_path_shifter (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .data (SRAM_data_in),
    .msb  (path_msb),
    .last (path_last)
  );

  assign chars_done_inc = chars_done_q + 32'd1;

  // Strobes are only ever raised while enabled and out of reset, so a frozen
  // or resetting block presents all-zero handshakes to its neighbours.
  always_comb begin
    state_d      = state_q;
    char_index_d = char_index_q;
    tot_chars_d  = tot_chars_q;
    chars_done_d = chars_done_q;
    load         = 1'b0;
    shift        = 1'b0;
    SPI_read_en  = 1'b0;
    SRAM_read_en = 1'b0;
    SPI_write_en = 1'b0;
    SPI_data_out = 1'b0;

    if (translation_enable && !rst) begin
      case (state_q)
        INIT: begin
          tot_chars_d  = tot_chars;
          chars_done_d = '0;
          if (tot_chars == 32'd0) begin
            state_d = FINISH;
          end else begin
            SPI_read_en = 1'b1;
            state_d     = CAPTURE_CHAR;
          end
        end
        CAPTURE_CHAR: begin
          char_index_d = SPI_data_in;
          state_d      = REQ_PATH;
        end
        REQ_PATH: begin
          SRAM_read_en = 1'b1;
          state_d      = LOAD_PATH;
        end
        LOAD_PATH: begin
          load    = 1'b1;
          state_d = WRITE_PATH;
        end
        WRITE_PATH: begin
          SPI_write_en = 1'b1;
          SPI_data_out = path_msb;
          if (SPI_write_ready) begin
            shift = 1'b1;
            if (path_last) begin
              chars_done_d = chars_done_inc;
              // The next read overlaps the last beat to keep a 131-cycle period.
              if (chars_done_inc == tot_chars_q) begin
                state_d = FINISH;
              end else begin
                SPI_read_en = 1'b1;
                state_d     = CAPTURE_CHAR;
              end
            end
          end
        end
        FINISH: begin
          state_d = FINISH;
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      char_index_q <= '0;
      tot_chars_q  <= '0;
      chars_done_q <= '0;
    end else begin
      state_q      <= state_d;
      char_index_q <= char_index_d;
      tot_chars_q  <= tot_chars_d;
      chars_done_q <= chars_done_d;
    end
  end

  assign char_index = char_index_q;
  assign finished   = (state_q == FINISH);

`ifdef T05_ENCODE_BITCOUNT_EN
  logic [39:0] bits_written_q, bits_written_d;

  always_comb begin
    bits_written_d = bits_written_q;
    if (shift) begin
      bits_written_d = bits_written_q + 40'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_written_q <= '0;
    end else begin
      bits_written_q <= bits_written_d;
    end
  end

  assign bits_written = bits_written_q;
`endif

endmodule

// File: tb/tb_t05_translation_encode.sv
// Scoreboard bench for t05_translation_encode: a negedge monitor pops expected
// path bits queued at each character request and compares every accepted beat.
module tb_t05_translation_encode;

  localparam int PATH_W = 128;
  localparam int CHAR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              translation_enable;
  logic [31:0]       tot_chars;
  logic [CHAR_W-1:0] SPI_data_in;
  logic [PATH_W-1:0] SRAM_data_in;
  logic              SPI_write_ready;
  logic              SPI_read_en;
  logic              SRAM_read_en;
  logic [CHAR_W-1:0] char_index;
  logic              SPI_data_out;
  logic              SPI_write_en;
  logic              finished;
`ifdef T05_ENCODE_BITCOUNT_EN
  logic [39:0]       bits_written;
`endif

  t05_translation_encode #(
    .PATH_W(PATH_W),
    .CHAR_W(CHAR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .translation_enable(translation_enable),
    .tot_chars         (tot_chars),
    .SPI_data_in       (SPI_data_in),
    .SRAM_data_in      (SRAM_data_in),
    .SPI_write_ready   (SPI_write_ready),
    .SPI_read_en       (SPI_read_en),
    .SRAM_read_en      (SRAM_read_en),
    .char_index        (char_index),
    .SPI_data_out      (SPI_data_out),
    .SPI_write_en      (SPI_write_en),
    .finished          (finished)
`ifdef T05_ENCODE_BITCOUNT_EN
    ,
    .bits_written      (bits_written)
`endif
  );

  always #5 clk = ~clk;

  // Reference data: codebook contents and the character stream per case.
  logic [PATH_W-1:0] mem [256];
  logic [CHAR_W-1:0] stim_chars [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor-owned scoreboard state
  logic              bit_q [$];
  logic [CHAR_W-1:0] char_q [$];
  int                rd_cyc [$];
  int                beat_cnt;
  int                rd_cnt;
  int                extra;
  int                fin_cyc;
  int                sram_cyc0;
  int                spi_req_cyc = -10;
  int                sram_req_cyc = -10;
  logic [CHAR_W-1:0] spi_req_val;
  logic [PATH_W-1:0] sram_req_val;
  logic [CHAR_W-1:0] mon_c;

  // Stimulus-owned state
  int ready_mode;
  int stall_used;
  int en_cyc;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: SPI reader and SRAM answer one cycle after each request,
  // garbage otherwise; write-ready follows the per-case mode.
  always @(posedge clk) begin
    #1;
    if (rst) stall_used = 0;
    SPI_data_in  = (spi_req_cyc == cyc - 1) ? spi_req_val : CHAR_W'($urandom);
    SRAM_data_in = (sram_req_cyc == cyc - 1) ? sram_req_val
                                              : {$urandom, $urandom, $urandom, $urandom};
    case (ready_mode)
      1: SPI_write_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (beat_cnt == 60 && stall_used < 5) begin
          SPI_write_ready = 1'b0;
          stall_used++;
        end else begin
          SPI_write_ready = 1'b1;
        end
      end
      default: SPI_write_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      bit_q.delete();
      char_q.delete();
      rd_cyc.delete();
      beat_cnt  = 0;
      rd_cnt    = 0;
      extra     = 0;
      fin_cyc   = -1;
      sram_cyc0 = -1;
    end else begin
      if (!translation_enable) begin
        check("freeze_strobes", 128'({SPI_read_en, SRAM_read_en, SPI_write_en, SPI_data_out}), 128'(0));
        if (rd_cyc.size() > 0 && fin_cyc < 0) extra++;
      end
      if (finished && fin_cyc >= 0)
        check("post_finish_strobes", 128'({SPI_read_en, SRAM_read_en, SPI_write_en, SPI_data_out}), 128'(0));
      if (finished && fin_cyc < 0) fin_cyc = cyc;
      if (!SPI_write_en) check("idle_dout", 128'(SPI_data_out), 128'(0));

      if (SPI_write_en) begin
        if (bit_q.size() == 0) begin
          check("unexpected_write", 128'(SPI_write_en), 128'(0));
        end else if (SPI_write_ready) begin
          check("beat", 128'(SPI_data_out), 128'(bit_q.pop_front()));
          beat_cnt++;
        end else begin
          check("stall_hold", 128'(SPI_data_out), 128'(bit_q[0]));
          if (fin_cyc < 0) extra++;
        end
      end

      if (SPI_read_en) begin
        if (SPI_write_en)
          check("read_write_overlap", 128'({SPI_write_ready, bit_q.size() == 0}), 128'(2'b11));
        if (rd_cnt >= int'(tot_chars)) begin
          check("unexpected_read", 128'(rd_cnt), 128'(tot_chars));
        end else begin
          mon_c = stim_chars[rd_cnt];
          rd_cnt++;
          rd_cyc.push_back(cyc);
          spi_req_cyc = cyc;
          spi_req_val = mon_c;
          char_q.push_back(mon_c);
          for (int i = 0; i < PATH_W; i++) bit_q.push_back(mem[mon_c][PATH_W-1-i]);
        end
      end

      if (SRAM_read_en) begin
        if (char_q.size() == 0) begin
          check("unexpected_sram_read", 128'(SRAM_read_en), 128'(0));
        end else begin
          mon_c = char_q.pop_front();
          check("char_index", 128'(char_index), 128'(mon_c));
          if (sram_cyc0 < 0) sram_cyc0 = cyc;
          sram_req_cyc = cyc;
          sram_req_val = mem[mon_c];
        end
      end
    end
  end

  task automatic run_case(input string name, input int n, input int rmode,
                          input bit frz, input bit rst_mid);
    @(posedge clk);
    #1;
    rst = 1'b1;
    translation_enable = 1'b0;
    tot_chars = 32'(n);
    ready_mode = rmode;
    #1;
    check({name, "_reset_outputs"},
          128'({SPI_read_en, SRAM_read_en, SPI_write_en, SPI_data_out, finished, char_index}), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 translation_enable = 1'b1;
    en_cyc = cyc;

    if (frz) begin
      for (int i = 0; i < 3000 && beat_cnt < 50; i++) @(posedge clk);
      #1 translation_enable = 1'b0;
      repeat (10) @(posedge clk);
      #1 translation_enable = 1'b1;
    end

    if (rst_mid) begin
      for (int i = 0; i < 3000 && beat_cnt < 30; i++) @(posedge clk);
      #3 rst = 1'b1;
      translation_enable = 1'b0;
      #1;
      check({name, "_async_reset_outputs"},
            128'({SPI_read_en, SRAM_read_en, SPI_write_en, SPI_data_out, finished, char_index}), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 translation_enable = 1'b1;
      en_cyc = cyc;
    end

    for (int i = 0; i < 200 + 400 * n && fin_cyc < 0; i++) @(posedge clk);
    #1;
    check({name, "_finished"}, 128'(finished), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    check({name, "_beat_total"}, 128'(beat_cnt), 128'(PATH_W * n));
    check({name, "_bits_left"}, 128'(bit_q.size()), 128'(0));
    check({name, "_chars_read"}, 128'(rd_cnt), 128'(n));
    if (n == 0) begin
      check({name, "_finish_latency"}, 128'(fin_cyc - en_cyc <= 2 && fin_cyc > en_cyc), 128'(1));
    end else begin
      check({name, "_finish_cycle"}, 128'(fin_cyc - rd_cyc[0]), 128'(131 * n + 1 + extra));
      check({name, "_sram_read_cycle"}, 128'(sram_cyc0 - rd_cyc[0]), 128'(2));
    end
    if (rmode == 0 && !frz) begin
      for (int k = 1; k < rd_cyc.size(); k++)
        check({name, "_read_spacing"}, 128'(rd_cyc[k] - rd_cyc[0]), 128'(131 * k));
    end
    if (rmode == 2) begin
      check({name, "_stall_cycles"}, 128'(stall_used), 128'(5));
      check({name, "_stall_delay"}, 128'(extra), 128'(5));
    end
    if (frz) check({name, "_freeze_delay"}, 128'(extra), 128'(10));
`ifdef T05_ENCODE_BITCOUNT_EN
    check({name, "_bits_written"}, 128'(bits_written), 128'(PATH_W * n));
`endif
    $display("case %s chars=%0d beats=%0d extra_cycles=%0d finish_cycle=%0d",
             name, n, beat_cnt, extra, fin_cyc);
  endtask

  initial begin
    rst = 1'b1;
    translation_enable = 1'b0;
    tot_chars = '0;
    SPI_data_in = '0;
    SRAM_data_in = '0;
    SPI_write_ready = 1'b1;
    ready_mode = 0;
    stall_used = 0;
    en_cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[8'h41] = {8'hA5, 120'd0};
    for (int i = 0; i < 16; i++) stim_chars[i] = '0;
    repeat (2) @(posedge clk);

    run_case("empty", 0, 0, 1'b0, 1'b0);

    stim_chars[0] = 8'h41;
    run_case("single", 1, 0, 1'b0, 1'b0);
    run_case("stall", 1, 2, 1'b0, 1'b0);
    run_case("freeze", 1, 0, 1'b1, 1'b0);

    stim_chars[0] = 8'h00;
    stim_chars[1] = 8'hFF;
    stim_chars[2] = 8'h41;
    run_case("back_to_back", 3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) stim_chars[i] = CHAR_W'($urandom);
    run_case("reset_mid", 2, 0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) stim_chars[i] = CHAR_W'($urandom);
    run_case("random_ready", 4, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
